// File: rtl/sd_spi_arbiter.sv
// sd_spi_arbiter
// Shares one sdspihost between two block-level clients. A requester owns the
// host from its req rise until its req fall, plus however long the host stays
// busy afterwards. Priority alternates between the requesters. The owner's
// strobes, address and write byte reach the host. Non-owners see busy=1, and
// their strobes are dropped. An optional watchdog revokes an owner that holds
// the grant too long. The revoked requester must drop req before it can be
// granted again.
module sd_spi_arbiter #(
    parameter logic [31:0] HOLD_LIMIT = 32'h0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [1:0]  req,
    output logic [1:0]  gnt,

    input  logic [1:0]  rq_r_block,
    input  logic [1:0]  rq_r_byte,
    input  logic [1:0]  rq_r_multi_block,
    input  logic [1:0]  rq_spi_rst,
    input  logic [1:0]  rq_w_block,
    input  logic [1:0]  rq_w_byte,
    input  logic [63:0] rq_block_addr,
    input  logic [15:0] rq_data_in,
    output logic [1:0]  rq_busy,
    output logic [1:0]  rq_err,
    output logic [1:0]  rq_crc_err,
    output logic [7:0]  rq_data_out,

    input  logic        spi_busy,
    input  logic        spi_err,
    input  logic        spi_crc_err,
    input  logic [7:0]  spi_data_out,
    output logic        spi_r_block,
    output logic        spi_r_byte,
    output logic        spi_r_multi_block,
    output logic        spi_rst,
    output logic        spi_w_block,
    output logic        spi_w_byte,
    output logic [31:0] spi_block_addr,
    output logic [7:0]  spi_data_in,

    output logic        owner_valid,
    output logic        owner_id,
    output logic        wdog_expired
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_gnt;
    logic        r_rr_ptr;
    logic        r_owner_id;
    logic        r_owner_valid;
    logic        r_wdog_expired;
    logic [31:0] r_hold_cnt;
    logic [1:0]  r_stale;

    logic        w_in_grant;
    logic        w_fwd;
    logic [1:0]  w_eligible;
    logic        w_pick;
    logic        w_wdog_hit;
    logic [1:0]  w_owner_mask;

    assign w_in_grant   = (r_state == ST_GRANT);
    // The owner's strobes are cut in the same cycle that its req falls.
    assign w_fwd        = w_in_grant & req[r_owner_id];
    assign w_eligible   = req & ~r_stale;
    assign w_pick       = w_eligible[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
    assign w_wdog_hit   = (HOLD_LIMIT != 32'd0) && (r_hold_cnt == HOLD_LIMIT - 32'd1);
    assign w_owner_mask = r_owner_id ? 2'b10 : 2'b01;

    // Route the owner's command onto the host. Without a grant, drive idle values.
    // NOTE: every output gets a default first, so no path through the block can infer a latch.
    always_comb begin
        spi_r_block       = 1'b0;
        spi_r_byte        = 1'b0;
        spi_r_multi_block = 1'b0;
        spi_rst           = 1'b0;
        spi_w_block       = 1'b0;
        spi_w_byte        = 1'b0;
        spi_block_addr    = 32'h0;
        spi_data_in       = 8'hFF;
        if (w_in_grant) begin
            spi_r_block       = w_fwd & rq_r_block[r_owner_id];
            spi_r_byte        = w_fwd & rq_r_byte[r_owner_id];
            spi_r_multi_block = w_fwd & rq_r_multi_block[r_owner_id];
            spi_rst           = w_fwd & rq_spi_rst[r_owner_id];
            spi_w_block       = w_fwd & rq_w_block[r_owner_id];
            spi_w_byte        = w_fwd & rq_w_byte[r_owner_id];
            spi_block_addr    = r_owner_id ? rq_block_addr[63:32] : rq_block_addr[31:0];
            spi_data_in       = r_owner_id ? rq_data_in[15:8] : rq_data_in[7:0];
        end
    end

    // Requester-side status. Only the owner sees the live host status; every other view reads busy.
    always_comb begin
        rq_busy    = 2'b11;
        rq_err     = 2'b00;
        rq_crc_err = 2'b00;
        if (w_in_grant) begin
            rq_busy[r_owner_id]    = spi_busy;
            rq_err[r_owner_id]     = spi_err;
            rq_crc_err[r_owner_id] = spi_crc_err;
        end
    end

    assign rq_data_out  = spi_data_out;
    assign gnt          = r_gnt;
    assign owner_valid  = r_owner_valid;
    assign owner_id     = r_owner_id;
    assign wdog_expired = r_wdog_expired;

    // Arbitration FSM, grant registers, hold counter and stale flags.
    // NOTE: state is updated only with non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_gnt          <= 2'b00;
            r_rr_ptr       <= 1'b0;
            r_owner_id     <= 1'b0;
            r_owner_valid  <= 1'b0;
            r_wdog_expired <= 1'b0;
            r_hold_cnt     <= 32'h0;
            r_stale        <= 2'b00;
        end else begin
            r_wdog_expired <= 1'b0;
            // A requester's stale flag clears on any cycle where its req is low.
            r_stale        <= r_stale & req;
            case (r_state)
                ST_IDLE: begin
                    if (w_eligible != 2'b00) begin
                        r_state       <= ST_GRANT;
                        r_gnt         <= w_pick ? 2'b10 : 2'b01;
                        r_owner_id    <= w_pick;
                        r_owner_valid <= 1'b1;
                        r_hold_cnt    <= 32'h0;
                    end
                end
                ST_GRANT: begin
                    if (!req[r_owner_id]) begin
                        r_state       <= ST_DRAIN;
                        r_gnt         <= 2'b00;
                        r_owner_valid <= 1'b0;
                    end else if (w_wdog_hit) begin
                        r_state        <= ST_DRAIN;
                        r_gnt          <= 2'b00;
                        r_owner_valid  <= 1'b0;
                        r_wdog_expired <= 1'b1;
                        r_stale        <= (r_stale & req) | w_owner_mask;
                    end else if (r_hold_cnt != 32'hFFFF_FFFF) begin
                        r_hold_cnt <= r_hold_cnt + 32'd1;
                    end
                end
                ST_DRAIN: begin
                    if (!spi_busy) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= ~r_owner_id;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_gnt         <= 2'b00;
                    r_owner_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// tb_sd_spi_arbiter
// Directed bench for sd_spi_arbiter with HOLD_LIMIT=100. Inputs are driven
// 1 time unit after each rising edge. Outputs are compared 1 time unit after
// that, well clear of the next edge.
module tb_sd_spi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  rq_r_block, rq_r_byte, rq_r_multi_block, rq_spi_rst, rq_w_block, rq_w_byte;
    logic [63:0] rq_block_addr;
    logic [15:0] rq_data_in;
    logic [1:0]  rq_busy, rq_err, rq_crc_err;
    logic [7:0]  rq_data_out;
    logic        spi_busy, spi_err, spi_crc_err;
    logic [7:0]  spi_data_out;
    logic        spi_r_block, spi_r_byte, spi_r_multi_block, spi_rst, spi_w_block, spi_w_byte;
    logic [31:0] spi_block_addr;
    logic [7:0]  spi_data_in;
    logic        owner_valid, owner_id, wdog_expired;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sd_spi_arbiter #(.HOLD_LIMIT(32'd100)) dut (
        .clk(clk), .rst(rst),
        .req(req), .gnt(gnt),
        .rq_r_block(rq_r_block), .rq_r_byte(rq_r_byte),
        .rq_r_multi_block(rq_r_multi_block), .rq_spi_rst(rq_spi_rst),
        .rq_w_block(rq_w_block), .rq_w_byte(rq_w_byte),
        .rq_block_addr(rq_block_addr), .rq_data_in(rq_data_in),
        .rq_busy(rq_busy), .rq_err(rq_err), .rq_crc_err(rq_crc_err),
        .rq_data_out(rq_data_out),
        .spi_busy(spi_busy), .spi_err(spi_err), .spi_crc_err(spi_crc_err),
        .spi_data_out(spi_data_out),
        .spi_r_block(spi_r_block), .spi_r_byte(spi_r_byte),
        .spi_r_multi_block(spi_r_multi_block), .spi_rst(spi_rst),
        .spi_w_block(spi_w_block), .spi_w_byte(spi_w_byte),
        .spi_block_addr(spi_block_addr), .spi_data_in(spi_data_in),
        .owner_valid(owner_valid), .owner_id(owner_id), .wdog_expired(wdog_expired)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; req = 2'b00;
        rq_r_block = 2'b00; rq_r_byte = 2'b00; rq_r_multi_block = 2'b00;
        rq_spi_rst = 2'b00; rq_w_block = 2'b00; rq_w_byte = 2'b00;
        rq_block_addr = 64'h0; rq_data_in = 16'h0;
        spi_busy = 1'b0; spi_err = 1'b1; spi_crc_err = 1'b1; spi_data_out = 8'h5A;
        cyc(2);
        rst = 1'b0;
        #1;
        // ---- reset state
        check("rst_gnt", gnt, 2'b00);
        check("rst_owner_valid", owner_valid, 1'b0);
        check("rst_owner_id", owner_id, 1'b0);
        check("rst_wdog", wdog_expired, 1'b0);
        check("rst_strobes", {spi_r_block, spi_r_byte, spi_r_multi_block, spi_rst, spi_w_block, spi_w_byte}, 6'b0);
        check("rst_addr", spi_block_addr, 32'h0);
        check("rst_data_in", spi_data_in, 8'hFF);
        check("rst_views", {rq_busy, rq_err, rq_crc_err}, 6'b110000);
        check("data_out_bcast", rq_data_out, 8'h5A);

        // ---- single requester
        req = 2'b01;
        cyc(1);
        check("t1_gnt", gnt, 2'b01);
        check("t1_owner", {owner_valid, owner_id}, 2'b10);
        rq_r_block = 2'b01; rq_block_addr[31:0] = 32'h0010_0000;
        #1;
        check("t1_r_block", spi_r_block, 1'b1);
        check("t1_addr", spi_block_addr, 32'h0010_0000);
        check("t1_views", {rq_busy, rq_err, rq_crc_err}, 6'b100101);
        req = 2'b00;
        #1;
        check("t1_strobe_cut", spi_r_block, 1'b0);
        cyc(1);
        check("t1_drain_gnt", gnt, 2'b00);
        cyc(1);
        check("t1_idle_gnt", {gnt, owner_valid}, 3'b000);
        check("t1_idle_owner_id", owner_id, 1'b0);
        rq_r_block = 2'b00;

        // ---- simultaneous requests, round-robin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        req = 2'b11;
        cyc(1);
        check("t2_first", gnt, 2'b01);
        req = 2'b10;
        cyc(1);
        check("t2_drain", gnt, 2'b00);
        cyc(1);
        check("t2_idle", gnt, 2'b00);
        cyc(1);
        check("t2_second", gnt, 2'b10);
        check("t2_owner_id", owner_id, 1'b1);
        req = 2'b01;
        cyc(1);
        req = 2'b11;
        cyc(1);
        check("t2_idle2", gnt, 2'b00);
        cyc(1);
        check("t2_alternate", gnt, 2'b01);

        // ---- isolation of the non-owner
        rq_w_block = 2'b10; rq_w_byte = 2'b10; rq_data_in = 16'hA53C;
        rq_block_addr = 64'hDEAD_BEEF_0000_0042;
        #1;
        check("t3_w_block", {spi_w_block, spi_w_byte}, 2'b00);
        check("t3_data_in", spi_data_in, 8'h3C);
        check("t3_addr", spi_block_addr, 32'h0000_0042);
        check("t3_busy", rq_busy, 2'b10);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            rq_w_block = {~rq_w_block[1], 1'b0};
            rq_w_byte  = {~rq_w_byte[1], 1'b1};
            #1;
            check("t3_loop_host", {spi_w_block, spi_w_byte, spi_data_in}, {2'b01, 8'h3C});
            check("t3_loop_busy1", rq_busy[1], 1'b1);
        end

        // ---- drain with the host busy
        spi_busy = 1'b1;
        req = 2'b10;
        #1;
        check("t4_strobe_cut", spi_w_byte, 1'b0);
        cyc(1);
        check("t4_gnt_drop", gnt, 2'b00);
        check("t4_busy_views", rq_busy, 2'b11);
        for (int i = 0; i < 19; i++) begin
            cyc(1);
            check("t4_hold_off", gnt, 2'b00);
        end
        spi_busy = 1'b0;
        cyc(1);
        check("t4_idle", gnt, 2'b00);
        cyc(1);
        check("t4_next_owner", gnt, 2'b10);
        rq_w_block = 2'b00; rq_w_byte = 2'b00;
        req = 2'b00;
        cyc(2);

        // ---- watchdog (HOLD_LIMIT=100)
        req = 2'b01;
        cyc(1);
        check("t5_grant", gnt, 2'b01);
        for (int i = 1; i < 100; i++) begin
            cyc(1);
            check("t5_held", {gnt, wdog_expired}, 3'b010);
        end
        cyc(1);
        check("t5_revoke", {gnt, wdog_expired}, 3'b001);
        cyc(1);
        check("t5_pulse_once", wdog_expired, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("t5_stale", gnt, 2'b00);
        end
        req = 2'b00;
        cyc(1);
        check("t5_released", gnt, 2'b00);
        req = 2'b01;
        cyc(1);
        check("t5_regrant", gnt, 2'b01);

        // ---- reset during grant
        rq_w_block = 2'b01; rq_data_in = 16'h0077;
        #1;
        check("t6_pre", {spi_w_block, spi_data_in}, {1'b1, 8'h77});
        rst = 1'b1; req = 2'b11;
        cyc(1);
        rst = 1'b0;
        #1;
        check("t6_gnt", {gnt, owner_valid}, 3'b000);
        check("t6_strobes", {spi_r_block, spi_r_byte, spi_r_multi_block, spi_rst, spi_w_block, spi_w_byte}, 6'b0);
        check("t6_data_in", spi_data_in, 8'hFF);
        cyc(1);
        check("t6_rr_ptr", gnt, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_spi_arbiter.md
Name: sd_spi_arbiter

Overview:
- Two-requester arbiter that shares one sdspihost instance between block-level clients, e.g. fsm_autotest and a result/log dumper.
- Uses a req/gnt handshake with round-robin priority.
- Ownership is held for a whole block transaction, from req rise to req fall plus host drain.
- Non-owners are isolated: their strobes are ignored and they see busy=1. An optional watchdog revokes a hung owner.

Parameters:
- HOLD_LIMIT, 32'h0: max cycles an owner may hold the grant; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req  in  2  per-requester request, bit n = requester n
- gnt  out  2  one-hot grant, registered
- rq_r_block  in  2  per-requester read-block strobe
- rq_r_byte  in  2  per-requester read-byte strobe
- rq_r_multi_block  in  2  per-requester multi-block strobe
- rq_spi_rst  in  2  per-requester host reset strobe
- rq_w_block  in  2  per-requester write-block strobe
- rq_w_byte  in  2  per-requester write-byte strobe
- rq_block_addr  in  64  [32n+31:32n] = block address of requester n
- rq_data_in  in  16  [8n+7:8n] = write byte of requester n
- rq_busy  out  2  per-requester busy view
- rq_err  out  2  per-requester err view
- rq_crc_err  out  2  per-requester crc_err view
- rq_data_out  out  8  host read byte, broadcast to both requesters
- spi_busy, spi_err, spi_crc_err  in  1 each  from host
- spi_data_out  in  8  from host
- spi_r_block, spi_r_byte, spi_r_multi_block, spi_rst, spi_w_block, spi_w_byte  out  1 each  to host
- spi_block_addr  out  32  to host
- spi_data_in  out  8  to host
- owner_valid  out  1  a grant is active
- owner_id  out  1  index of current/last owner
- wdog_expired  out  1  one-cycle pulse when the watchdog revokes a grant

Behaviour:
- Reset: rst is synchronous, active-high, on clk. State=IDLE, gnt=0, rr_ptr=0, owner_id=0, owner_valid=0, wdog_expired=0, hold counter=0, stale flags=0.
- Reset effect on host outputs: all host strobes 0, spi_block_addr=0, spi_data_in=8'hFF.
- Reset mid-transaction: the grant is dropped immediately; no drain.
- States:
  - IDLE: compute eligible = req & ~stale. If eligible is nonzero, pick eligible[rr_ptr] if set, else the other requester. Go to GRANT; gnt/owner_id/owner_valid update on that edge. Latency from req rise to gnt is 1 cycle when the arbiter is idle.
  - GRANT: host strobes, addr and data_in are muxed combinationally from the owner.
    - Exit when req[owner]=0: go to DRAIN, and strobes are forced 0 combinationally from the same cycle.
    - Exit when HOLD_LIMIT!=0 and the hold counter equals HOLD_LIMIT-1: go to DRAIN, pulse wdog_expired, set stale[owner]=1.
  - DRAIN: gnt=0, strobes forced 0. When spi_busy=0, go to IDLE and set rr_ptr=~owner_id. Minimum one cycle in DRAIN.
- Host outputs with no grant (IDLE/DRAIN): all strobes 0, spi_block_addr=0, spi_data_in=8'hFF.
- Requester-side views:
  - Owner: rq_busy = spi_busy, rq_err = spi_err, rq_crc_err = spi_crc_err.
  - Non-owner, and everyone in IDLE/DRAIN: rq_busy=1, rq_err=0, rq_crc_err=0.
- Hold counter: 32-bit. Cleared on entering GRANT and increments each GRANT cycle. Saturates; never wraps.
- Stale flag: stale[n] clears on any cycle where req[n]=0. A revoked requester must drop req for at least 1 cycle before it is eligible again.
- Simultaneous requests in IDLE: rr_ptr decides.
- A requester whose req rises during the other's GRANT/DRAIN waits. It is granted in the cycle after DRAIN→IDLE, because IDLE lasts exactly one cycle when eligible is nonzero.
- Strobes asserted without gnt: ignored entirely; they never reach the host.
- owner_id holds the last owner while IDLE.

Test Plan:
- Single requester: req[0]=1 at cycle 10 → gnt=2'b01 at 11. The owner's r_block and block_addr=32'h00100000 appear on the host the same cycle they are driven. Drop req with spi_busy=0 → DRAIN → IDLE two cycles later, gnt=0.
- Simultaneous req=2'b11 after reset → requester 0 granted. After its release, requester 1 is granted with no extra idle cycle beyond DRAIN+IDLE. Next contention → requester 0 (round-robin alternates).
- Isolation: requester 1 toggles w_block/w_byte and data_in=8'hA5 while requester 0 owns → host sees only requester 0 values, and rq_busy[1]=1 throughout.
- Drain: owner drops req while spi_busy=1 for 20 cycles → gnt drops next cycle, strobes 0 immediately, the other requester is granted only after spi_busy falls.
- Watchdog with HOLD_LIMIT=100: owner holds req → gnt drops after exactly 100 grant cycles and wdog_expired pulses once. With req still high, that requester is never regranted. After 1 cycle of req=0 followed by req=1, it is regranted.
- Reset asserted during GRANT with spi_w_block=1 → next cycle gnt=0, all host strobes 0, spi_data_in=8'hFF, rr_ptr=0.
